sqrt_arbiter: RTL

Round-robin front end that shares one `sqrt_calculator` engine among `NREQ` independent requesters. It accepts one request at a time, issues a start to the engine, and waits for `done` under a watchdog timeout. It then returns the result, plus error and timeout flags, to the granted requester with valid/ready backpressure. It sits between client blocks and the engine's `sqrt_intf`, and it is the only driver of the engine's `start`/`in`.

---
 rtl/sqrt_pkg.sv | 10 +
 rtl/sqrt_arbiter_if.sv | 35 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/sqrt_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared types and defaults for the sqrt engine front end
package sqrt_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sqrt_arb_state_t;

  localparam int SQRT_DW      = 32;
  localparam int SQRT_NREQ    = 4;
  localparam int SQRT_TIMEOUT = 32;

endpackage

// File: rtl/sqrt_arbiter_if.sv
// rtl/sqrt_arbiter_if.sv - requester and engine signal bundle of sqrt_arbiter
interface sqrt_arbiter_if #(
  parameter int NREQ = sqrt_pkg::SQRT_NREQ,
  parameter int DW   = sqrt_pkg::SQRT_DW
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*DW-1:0]      req_data;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic [DW-1:0]           rsp_data;
  logic                    rsp_error;
  logic                    rsp_timeout;
  logic                    eng_start;
  logic [DW-1:0]           eng_in;
  logic [DW-1:0]           eng_out;
  logic                    eng_error;
  logic                    eng_done;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] grant_id;

  modport slave (
    input  req_valid, req_data, rsp_ready, eng_out, eng_error, eng_done,
    output req_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout,
           eng_start, eng_in, busy, grant_id
  );

  modport master (
    output req_valid, req_data, rsp_ready, eng_out, eng_error, eng_done,
    input  req_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout,
           eng_start, eng_in, busy, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting after last_id
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_id,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id
);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the closest requester after last_id wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_id) + k) % NREQ);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_id    = cand;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin front end sharing one sqrt engine among NREQ clients
module sqrt_arbiter
  import sqrt_pkg::*;
#(
  parameter int NREQ    = SQRT_NREQ,
  parameter int DW      = SQRT_DW,
  parameter int TIMEOUT = SQRT_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  sqrt_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  sqrt_arb_state_t state, next;

  logic [IW-1:0]   last_id;
  logic [IW-1:0]   id_q;
  logic [DW-1:0]   op_q;
  logic [DW-1:0]   res_q;
  logic            err_q;
  logic            to_q;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_id;
  logic            accept;
  logic            done_take;
  logic            to_take;
  logic            rsp_hs;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (bus.req_valid),
    .last_id (last_id),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next            = state;
    accept          = 1'b0;
    done_take       = 1'b0;
    to_take         = 1'b0;
    rsp_hs          = 1'b0;
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.rsp_data    = '0;
    bus.rsp_error   = 1'b0;
    bus.rsp_timeout = 1'b0;
    bus.eng_start   = 1'b0;
    bus.eng_in      = op_q;
    bus.busy        = (state != IDLE);
    bus.grant_id    = id_q;
    case (state)
      IDLE: begin
        bus.req_ready = gnt;
        if (|(bus.req_valid & gnt)) begin
          accept = 1'b1;
          next   = ISSUE;
        end
      end
      ISSUE: begin
        bus.eng_start = 1'b1;
        next          = WAIT;
      end
      WAIT: begin
        // A done arriving in the last watchdog cycle still delivers a real result.
        if (bus.eng_done) begin
          done_take = 1'b1;
          next      = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          to_take = 1'b1;
          next    = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid   = NREQ'(1) << id_q;
        bus.rsp_data    = res_q;
        bus.rsp_error   = err_q;
        bus.rsp_timeout = to_q;
        if (bus.rsp_ready[id_q]) begin
          rsp_hs = 1'b1;
          next   = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id <= IW'(NREQ - 1);
      id_q    <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        op_q <= bus.req_data[int'(gnt_id)*DW +: DW];
        id_q <= gnt_id;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (done_take) begin
        res_q <= bus.eng_out;
        err_q <= bus.eng_error;
        to_q  <= 1'b0;
      end else if (to_take) begin
        res_q <= '0;
        err_q <= 1'b1;
        to_q  <= 1'b1;
      end
      if (rsp_hs) last_id <= id_q;
    end
  end

endmodule
